sext_arbiter: RTL

Shares a single sign/zero-extension datapath between two requesters, the decode stage (port 0) and the branch/address unit (port 1), under round-robin arbitration. Each accepted immediate is extended to the datapath width and returned on the requester's own response port through a one-entry registered output stage with valid/ready backpressure. It sits between the instruction decoder/branch unit and the ALU operand muxes, so the microprocessor needs only one extender instance.

---
 rtl/sext_arbiter_if.sv | 36 +++
 rtl/sext_arbiter.sv | 77 +++++++
 2 files changed

// File: rtl/sext_arbiter_if.sv
// Request/response bundle for the shared immediate extender: two requesters,
// each with a valid/ready request channel and a valid/ready response channel.
interface sext_arbiter_if #(
    parameter int IN  = 16,
    parameter int OUT = 32
);
    logic           req0_valid;
    logic [IN-1:0]  req0_data;
    logic           req0_zext;
    logic           req0_ready;
    logic           rsp0_valid;
    logic [OUT-1:0] rsp0_data;
    logic           rsp0_ready;

    logic           req1_valid;
    logic [IN-1:0]  req1_data;
    logic           req1_zext;
    logic           req1_ready;
    logic           rsp1_valid;
    logic [OUT-1:0] rsp1_data;
    logic           rsp1_ready;

    modport slave (
        input  req0_valid, req0_data, req0_zext, rsp0_ready,
        input  req1_valid, req1_data, req1_zext, rsp1_ready,
        output req0_ready, rsp0_valid, rsp0_data,
        output req1_ready, rsp1_valid, rsp1_data
    );

    modport master (
        output req0_valid, req0_data, req0_zext, rsp0_ready,
        output req1_valid, req1_data, req1_zext, rsp1_ready,
        input  req0_ready, rsp0_valid, rsp0_data,
        input  req1_ready, rsp1_valid, rsp1_data
    );
endinterface

// File: rtl/sext_arbiter.sv
// One sign/zero extender shared by decode (port 0) and branch unit (port 1),
// round-robin arbitrated, with a single-entry registered result slot.
module sext_arbiter #(
    parameter int IN  = 16,
    parameter int OUT = 32
) (
    input  logic          clk,
    input  logic          rst,
    sext_arbiter_if.slave bus
);

    logic           r_out_valid;
    logic           r_out_owner;
    logic [OUT-1:0] r_out_data;
    logic           r_last_grant;

    logic           w_drain;
    logic           w_can_accept;
    logic           w_grant0;
    logic           w_grant1;
    logic [IN-1:0]  w_sel_data;
    logic           w_sel_zext;
    logic [OUT-1:0] w_ext;
    logic           w_rsp0_valid;
    logic           w_rsp1_valid;

    // The slot frees up either when empty or when its owner takes the result this cycle.
    assign w_drain      = r_out_valid && (r_out_owner ? bus.rsp1_ready : bus.rsp0_ready);
    assign w_can_accept = !r_out_valid || w_drain;

    always_comb begin
        // NOTE: defaults first so every path assigns both grants and no latch is inferred.
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (w_can_accept && !rst) begin
            if (bus.req0_valid && bus.req1_valid) begin
                w_grant0 = r_last_grant;
                w_grant1 = !r_last_grant;
            end else begin
                w_grant0 = bus.req0_valid;
                w_grant1 = bus.req1_valid;
            end
        end
    end

    assign w_sel_data = w_grant1 ? bus.req1_data : bus.req0_data;
    assign w_sel_zext = w_grant1 ? bus.req1_zext : bus.req0_zext;
    assign w_ext      = {{(OUT-IN){w_sel_data[IN-1] & ~w_sel_zext}}, w_sel_data};

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all updates land together at the edge.
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_owner  <= 1'b0;
            r_out_data   <= '0;
            r_last_grant <= 1'b1;
        end else if (w_grant0 || w_grant1) begin
            r_out_valid  <= 1'b1;
            r_out_owner  <= w_grant1;
            r_out_data   <= w_ext;
            r_last_grant <= w_grant1;
        end else if (w_drain) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign w_rsp0_valid = r_out_valid && !r_out_owner && !rst;
    assign w_rsp1_valid = r_out_valid &&  r_out_owner && !rst;

    assign bus.req0_ready = w_grant0;
    assign bus.req1_ready = w_grant1;
    assign bus.rsp0_valid = w_rsp0_valid;
    assign bus.rsp1_valid = w_rsp1_valid;
    assign bus.rsp0_data  = w_rsp0_valid ? r_out_data : '0;
    assign bus.rsp1_data  = w_rsp1_valid ? r_out_data : '0;

endmodule
